// File: rtl/cmp_pkg.sv
// Shared types and helpers for the magnitude-comparator search controller and its bench.
package cmp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        UPDATE,
        DONE,
        ERR
    } state_t;

    // Bit positions of the {A>B, A==B, A<B} flag vector.
    localparam int FLAG_GT = 2;
    localparam int FLAG_EQ = 1;
    localparam int FLAG_LT = 0;

    function automatic logic is_onehot3(input logic [2:0] flags);
        return (flags == 3'b001) || (flags == 3'b010) || (flags == 3'b100);
    endfunction

endpackage

// File: rtl/cmp_search_ctrl_if.sv
// Guess/result handshake between the search controller and the magnitude comparator.
interface cmp_search_ctrl_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] guess;
    logic             guess_valid;
    logic             res_valid;
    logic             a_gt_b;
    logic             a_eq_b;
    logic             a_lt_b;

    modport master (
        output guess, guess_valid,
        input  res_valid, a_gt_b, a_eq_b, a_lt_b
    );

    modport slave (
        input  guess, guess_valid,
        output res_valid, a_gt_b, a_eq_b, a_lt_b
    );
endinterface

// File: rtl/cmp_search_timer.sv
// Per-probe wait counter; expired flags the TIMEOUT-th consecutive waiting cycle.
module cmp_search_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Fires combinationally so the FSM leaves DRIVE exactly after TIMEOUT waiting cycles.
    assign expired = enable && (count_reg == CW'(TIMEOUT - 1));

endmodule

// File: rtl/cmp_search_ctrl.sv
// Binary-search initiator: drives operand B of the comparator and narrows [lo, hi]
// until the comparator reports equality, the interval is exhausted, or a protocol error.
module cmp_search_ctrl
    import cmp_pkg::*;
#(
    parameter int WIDTH   = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    cmp_search_ctrl_if.master             cmp,
    output logic                          busy,
    output logic                          done,
    output logic                          found,
    output logic [WIDTH-1:0]              result,
    output logic [$clog2(WIDTH+2)-1:0]    steps,
    output logic                          error
);
    localparam int                SW          = $clog2(WIDTH + 2);
    localparam logic [SW:0]       MAX_STEPS   = (SW+1)'(WIDTH + 1);
    localparam logic [WIDTH-1:0]  ALL_ONES    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]  START_GUESS = ALL_ONES >> 1;

    state_t           state_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] guess_reg;
    logic             guess_valid_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             found_reg;
    logic [WIDTH-1:0] result_reg;
    logic [SW-1:0]    steps_reg;
    logic             error_reg;

    logic [2:0]       flags;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH-1:0] mid_w;
    logic [SW:0]      steps_inc;
    logic             timer_expired;
    logic             in_drive;

    assign flags[FLAG_GT] = cmp.a_gt_b;
    assign flags[FLAG_EQ] = cmp.a_eq_b;
    assign flags[FLAG_LT] = cmp.a_lt_b;

    // Sum carried at WIDTH+1 bits so lo+hi never wraps.
    assign sum_w     = {1'b0, lo_reg} + {1'b0, hi_reg};
    assign mid_w     = WIDTH'(sum_w >> 1);
    assign steps_inc = {1'b0, steps_reg} + (SW+1)'(1);
    assign in_drive  = (state_reg == DRIVE);

    cmp_search_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_drive || cmp.res_valid),
        .enable  (in_drive && !cmp.res_valid),
        .expired (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            lo_reg          <= '0;
            hi_reg          <= ALL_ONES;
            guess_reg       <= '0;
            guess_valid_reg <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            found_reg       <= 1'b0;
            result_reg      <= '0;
            steps_reg       <= '0;
            error_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        lo_reg          <= '0;
                        hi_reg          <= ALL_ONES;
                        steps_reg       <= '0;
                        done_reg        <= 1'b0;
                        found_reg       <= 1'b0;
                        result_reg      <= '0;
                        error_reg       <= 1'b0;
                        guess_reg       <= START_GUESS;
                        guess_valid_reg <= 1'b1;
                        busy_reg        <= 1'b1;
                        state_reg       <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (cmp.res_valid) begin
                        guess_valid_reg <= 1'b0;
                        // Only inconsistent flags can push the count past WIDTH+1.
                        if (steps_inc > MAX_STEPS || !is_onehot3(flags)) begin
                            if (steps_inc <= MAX_STEPS) begin
                                steps_reg <= steps_inc[SW-1:0];
                            end
                            busy_reg  <= 1'b0;
                            error_reg <= 1'b1;
                            state_reg <= ERR;
                        end else begin
                            steps_reg <= steps_inc[SW-1:0];
                            if (flags[FLAG_EQ]) begin
                                found_reg  <= 1'b1;
                                result_reg <= guess_reg;
                                done_reg   <= 1'b1;
                                busy_reg   <= 1'b0;
                                state_reg  <= DONE;
                            end else if (flags[FLAG_GT] && guess_reg == hi_reg) begin
                                done_reg  <= 1'b1;
                                busy_reg  <= 1'b0;
                                state_reg <= DONE;
                            end else if (flags[FLAG_LT] && guess_reg == lo_reg) begin
                                done_reg  <= 1'b1;
                                busy_reg  <= 1'b0;
                                state_reg <= DONE;
                            end else if (flags[FLAG_GT]) begin
                                lo_reg    <= guess_reg + 1'b1;
                                state_reg <= UPDATE;
                            end else begin
                                hi_reg    <= guess_reg - 1'b1;
                                state_reg <= UPDATE;
                            end
                        end
                    end else if (timer_expired) begin
                        guess_valid_reg <= 1'b0;
                        busy_reg        <= 1'b0;
                        error_reg       <= 1'b1;
                        state_reg       <= ERR;
                    end
                end
                UPDATE: begin
                    guess_reg       <= mid_w;
                    guess_valid_reg <= 1'b1;
                    state_reg       <= DRIVE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign cmp.guess       = guess_reg;
    assign cmp.guess_valid = guess_valid_reg;
    assign busy            = busy_reg;
    assign done            = done_reg;
    assign found           = found_reg;
    assign result          = result_reg;
    assign steps           = steps_reg;
    assign error           = error_reg;

endmodule
